fir_decimator_requant: RTL and testbench

//  Downstream stage of the FIR filter. Keeps every Dth accepted filter output, rescales
//  it by a runtime right shift with round-half-up and signed saturation, and queues it in
//  a small output FIFO. It presents a valid/ready stream to the next DSP or packetiser stage.

---
 rtl/fir_decimator_requant.sv | 164 ++++++++++++++++
 tb/tb_fir_decimator_requant.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decimator_requant.sv
// Decimating requantiser: keeps every Dth FIR output, rounds/shifts/saturates it, queues it in a FIFO.
// Optional feature macro: DECIM_SAT_CNT_EN builds the 8-bit saturation event counter in status[15:8].
module fir_decimator_requant #(
    parameter int IN_WIDTH   = 18,
    parameter int OUT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [7:0]                  decim_factor,
    input  logic [4:0]                  shift,
    input  logic                        sat_clr,
    input  logic signed [IN_WIDTH-1:0]  din,
    input  logic                        din_valid,
    output logic                        din_ready,
    output logic signed [OUT_WIDTH-1:0] dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic [15:0]                 status
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [5:0] SHIFT_CAP = 6'(IN_WIDTH);
    localparam logic signed [IN_WIDTH:0] ONE = 1;
    localparam logic signed [IN_WIDTH:0] SAT_MAX = {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] SAT_MIN = {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic                        en_q;
    logic [7:0]                  d_eff;
    logic [7:0]                  d_req;
    logic [7:0]                  phase;
    logic                        accept;
    logic                        kept;
    logic [4:0]                  sh_eff;
    logic signed [IN_WIDTH:0]    ext;
    logic signed [IN_WIDTH:0]    rnd;
    logic signed [IN_WIDTH:0]    sum;
    logic signed [IN_WIDTH:0]    v;
    logic signed [OUT_WIDTH-1:0] q;
    logic                        clamp;
    logic                        sat_event;
    logic                        sat_sticky;
    logic [7:0]                  sat_cnt_q;
    logic                        s1_valid;
    logic signed [OUT_WIDTH-1:0] s1_data;
    logic signed [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [CW-1:0]               count;
    logic [CW-1:0]               count_nxt;
    logic [CW:0]                 occ_nxt;
    logic                        push;
    logic                        pop;

    assign d_req     = (decim_factor == 8'd0) ? 8'd1 : decim_factor;
    assign accept    = din_valid && din_ready;
    assign kept      = accept && (phase == 8'd0);
    assign sat_event = kept && clamp;

    // Shifts at or beyond the input width all round to zero, so capping keeps the
    // rounding constant inside IN_WIDTH+1 bits without changing the result.
    always_comb begin
        sh_eff = ({1'b0, shift} > SHIFT_CAP) ? SHIFT_CAP[4:0] : shift;
        ext    = {din[IN_WIDTH-1], din};
        rnd    = ONE << (sh_eff - 5'd1);
        sum    = ext + rnd;
        v      = sum >>> sh_eff;
        clamp  = 1'b0;
        q      = v[OUT_WIDTH-1:0];
        if (v > SAT_MAX) begin
            q     = SAT_MAX[OUT_WIDTH-1:0];
            clamp = 1'b1;
        end else if (v < SAT_MIN) begin
            q     = SAT_MIN[OUT_WIDTH-1:0];
            clamp = 1'b1;
        end
    end

    assign push       = s1_valid;
    assign dout_valid = (count != '0);
    assign pop        = dout_valid && dout_ready;
    assign dout       = dout_valid ? mem[rd_ptr] : '0;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!push && pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // Ready looks at next-cycle occupancy including the sample entering stage 1,
    // so every accepted sample is guaranteed a FIFO slot.
    assign occ_nxt = {1'b0, count_nxt} + {{CW{1'b0}}, kept};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            d_eff      <= d_req;
            phase      <= 8'd0;
            din_ready  <= 1'b0;
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            sat_sticky <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            en_q      <= enable;
            din_ready <= enable && (occ_nxt < {1'b0, DEPTH_C});
            if (!enable) begin
                d_eff <= d_req;
                phase <= 8'd0;
            end else if (accept) begin
                phase <= (phase == d_eff - 8'd1) ? 8'd0 : phase + 8'd1;
            end
            s1_valid <= kept;
            if (kept) begin
                s1_data <= q;
            end
            if (sat_event) begin
                sat_sticky <= 1'b1;
            end else if (sat_clr) begin
                sat_sticky <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= s1_data;
        end
    end

`ifdef DECIM_SAT_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_cnt_q <= 8'h00;
        end else if (sat_event) begin
            if (sat_cnt_q != 8'hFF) begin
                sat_cnt_q <= sat_cnt_q + 8'd1;
            end
        end else if (sat_clr) begin
            sat_cnt_q <= 8'h00;
        end
    end
`else
    assign sat_cnt_q = 8'h00;
`endif

    assign status = {sat_cnt_q, 4'(count), sat_sticky, (count == '0), (count == DEPTH_C), en_q};

endmodule

// File: tb/tb_fir_decimator_requant.sv
// Self-checking bench for fir_decimator_requant: randomized streams against a queue-based reference model.
module tb_fir_decimator_requant;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable = 1'b0;
    logic [7:0]         decim_factor = 8'd1;
    logic [4:0]         shift = 5'd0;
    logic               sat_clr = 1'b0;
    logic signed [17:0] din = '0;
    logic               din_valid = 1'b0;
    logic               din_ready;
    logic signed [15:0] dout;
    logic               dout_valid;
    logic               dout_ready = 1'b0;
    logic [15:0]        status;

    int                 n_tests = 0;
    int                 n_fail = 0;
    logic signed [15:0] exp_q[$];
    logic signed [15:0] got_q[$];
    int                 acc_idx = 0;
    int                 mdl_d = 1;
    bit                 mdl_sticky = 1'b0;
    int                 mdl_cnt = 0;
    bit                 last_acc = 1'b0;

    fir_decimator_requant #(
        .IN_WIDTH  (18),
        .OUT_WIDTH (16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .decim_factor(decim_factor),
        .shift       (shift),
        .sat_clr     (sat_clr),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .status      (status)
    );

    always #5 clk = ~clk;

    // Exact rounding arithmetic in 64 bits, then clamp to the 16-bit signed range.
    function automatic int requant_model(input int x, input int s, output bit clamped);
        longint t;
        t = longint'(x);
        if (s > 0) begin
            t = (t + (longint'(1) << (s - 1))) >>> s;
        end
        clamped = 1'b0;
        if (t > 32767) begin
            t = 32767;
            clamped = 1'b1;
        end else if (t < -32768) begin
            t = -32768;
            clamped = 1'b1;
        end
        return int'(t);
    endfunction

    // Observes the handshakes about to happen at the next rising edge, updates the model, advances.
    task automatic tick();
        bit acc;
        bit clamped;
        int v;
        int dm;
        acc = din_valid && din_ready;
        last_acc = acc && rst_n;
        dm = (decim_factor == 8'd0) ? 1 : int'(decim_factor);
        clamped = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            acc_idx = 0;
            mdl_d = dm;
            mdl_sticky = 1'b0;
            mdl_cnt = 0;
        end else begin
            if (acc) begin
                if (acc_idx % mdl_d == 0) begin
                    v = requant_model(int'(din), int'(shift), clamped);
                    exp_q.push_back(16'(v));
                end
                acc_idx++;
            end
            if (clamped) begin
                mdl_sticky = 1'b1;
                if (mdl_cnt < 255) mdl_cnt++;
            end else if (sat_clr) begin
                mdl_sticky = 1'b0;
                mdl_cnt = 0;
            end
            if (!enable) begin
                acc_idx = 0;
                mdl_d = dm;
            end
            if (dout_valid && dout_ready) got_q.push_back(dout);
        end
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!din_ready && n < 20) begin
            tick();
            n++;
        end
        if (!din_ready) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL wait_ready timeout: din_ready=%b required 1", din_ready);
        end
    endtask

    task automatic send(input logic signed [17:0] val);
        int n;
        n = 0;
        din = val;
        din_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 40);
        if (!last_acc) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL send timeout: sample %0d not accepted, required accept", val);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        din_valid = 1'b0;
        dout_ready = 1'b1;
        while ((got_q.size() < exp_q.size() || dout_valid) && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic configure(input logic [7:0] d, input logic [4:0] s);
        enable = 1'b0;
        din_valid = 1'b0;
        decim_factor = d;
        shift = s;
        tick();
        tick();
        enable = 1'b1;
        wait_ready();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        din_valid = 1'b1;
        din = 18'sd5;
        dout_ready = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (status !== 16'h0004) begin
            n_fail++;
            $display("[TB] FAIL reset_status: got %h required 0004", status);
        end
        n_tests++;
        if (dout !== 16'sd0) begin
            n_fail++;
            $display("[TB] FAIL reset_dout: got %0d required 0", dout);
        end
        n_tests++;
        if (dout_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_dout_valid: got %b required 0", dout_valid);
        end
        n_tests++;
        if (din_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_din_ready: got %b required 0", din_ready);
        end
        rst_n = 1'b1;
        enable = 1'b0;
        din_valid = 1'b0;
        tick();
        tick();
        n_tests++;
        if (status !== 16'h0004) begin
            n_fail++;
            $display("[TB] FAIL idle_status: got %h required 0004", status);
        end
    endtask

    task automatic test_passthrough();
        configure(8'd1, 5'd0);
        dout_ready = 1'b1;
        din = 18'sd1;
        din_valid = 1'b1;
        tick();
        n_tests++;
        if (dout_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL latency_early: dout_valid got %b required 0", dout_valid);
        end
        din = 18'sd2;
        tick();
        n_tests++;
        if (dout_valid !== 1'b1 || dout !== 16'sd1) begin
            n_fail++;
            $display("[TB] FAIL latency_first: valid=%b dout=%0d required valid=1 dout=1", dout_valid, dout);
        end
        for (int i = 3; i <= 8; i++) send(18'(i));
        drain();
        n_tests++;
        if (got_q.size() != 8) begin
            n_fail++;
            $display("[TB] FAIL passthrough_count: got %0d required 8", got_q.size());
        end
        for (int k = 0; k < got_q.size() && k < 8; k++) begin
            n_tests++;
            if (got_q[k] !== 16'(k + 1)) begin
                n_fail++;
                $display("[TB] FAIL passthrough_data[%0d]: got %0d required %0d", k, got_q[k], k + 1);
            end
        end
    endtask

    task automatic test_decimation();
        int drops;
        drops = 0;
        configure(8'd4, 5'd0);
        dout_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = 18'(i);
            din_valid = 1'b1;
            if (!din_ready) drops++;
            tick();
        end
        drain();
        n_tests++;
        if (drops != 0) begin
            n_fail++;
            $display("[TB] FAIL decim_ready_drop: got %0d stalls required 0", drops);
        end
        n_tests++;
        if (got_q.size() != 4) begin
            n_fail++;
            $display("[TB] FAIL decim_count: got %0d required 4", got_q.size());
        end
        for (int k = 0; k < got_q.size() && k < 4; k++) begin
            n_tests++;
            if (got_q[k] !== 16'(4 * k)) begin
                n_fail++;
                $display("[TB] FAIL decim_data[%0d]: got %0d required %0d", k, got_q[k], 4 * k);
            end
        end
    endtask

    task automatic test_requant();
        int exp_c[3];
        exp_c = '{2, -1, 32767};
        configure(8'd1, 5'd2);
        dout_ready = 1'b1;
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        send(18'sd7);
        send(-18'sd6);
        drain();
        n_tests++;
        if (status[3] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL sticky_no_clamp: got %b required 0", status[3]);
        end
        send(18'sd131071);
        drain();
        n_tests++;
        if (status[3] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL sticky_after_clamp: got %b required 1", status[3]);
        end
        n_tests++;
        if (got_q.size() != 3) begin
            n_fail++;
            $display("[TB] FAIL requant_count: got %0d required 3", got_q.size());
        end
        for (int k = 0; k < got_q.size() && k < 3; k++) begin
            n_tests++;
            if (got_q[k] !== 16'(exp_c[k])) begin
                n_fail++;
                $display("[TB] FAIL requant_data[%0d]: got %0d required %0d", k, got_q[k], exp_c[k]);
            end
        end
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 40; i++) begin
            shift = (i < 8) ? 5'(14 + i) : 5'($urandom_range(0, 31));
            if (i % 5 == 0) send((i % 10 == 0) ? -18'sd131072 : 18'sd131071);
            else send(18'($urandom));
        end
        drain();
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL requant_rand_count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            n_tests++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("[TB] FAIL requant_rand[%0d]: got %0d required %0d", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        configure(8'd1, 5'd0);
        dout_ready = 1'b0;
        din_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din = 18'($urandom);
            tick();
        end
        n_tests++;
        if (din_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL full_din_ready: got %b required 0", din_ready);
        end
        n_tests++;
        if (status[1] !== 1'b1 || status[7:4] !== 4'd4) begin
            n_fail++;
            $display("[TB] FAIL full_status: full=%b count=%0d required full=1 count=4", status[1], status[7:4]);
        end
        drain();
        n_tests++;
        if (got_q.size() != 4 || exp_q.size() != 4) begin
            n_fail++;
            $display("[TB] FAIL full_drain_count: got %0d model %0d required 4", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            n_tests++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("[TB] FAIL full_drain[%0d]: got %0d required %0d", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_decim_latch();
        int exp_c[6];
        exp_c = '{100, 102, 104, 106, 200, 203};
        configure(8'd2, 5'd0);
        dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) decim_factor = 8'd3;
            send(18'(100 + i));
        end
        din_valid = 1'b0;
        tick();
        enable = 1'b0;
        tick();
        tick();
        enable = 1'b1;
        wait_ready();
        for (int i = 0; i < 6; i++) send(18'(200 + i));
        drain();
        n_tests++;
        if (got_q.size() != 6) begin
            n_fail++;
            $display("[TB] FAIL latch_count: got %0d required 6", got_q.size());
        end
        for (int k = 0; k < got_q.size() && k < 6; k++) begin
            n_tests++;
            if (got_q[k] !== 16'(exp_c[k])) begin
                n_fail++;
                $display("[TB] FAIL latch_data[%0d]: got %0d required %0d", k, got_q[k], exp_c[k]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        configure(8'd1, 5'd0);
        dout_ready = 1'b0;
        din_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 18'(500 + i);
            tick();
        end
        rst_n = 1'b0;
        tick();
        n_tests++;
        if (dout_valid !== 1'b0 || status !== 16'h0004 || din_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset: valid=%b status=%h ready=%b required 0/0004/0", dout_valid, status, din_ready);
        end
        rst_n = 1'b1;
        configure(8'd1, 5'd0);
        dout_ready = 1'b1;
        send(18'sd42);
        drain();
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== 16'sd42) begin
            n_fail++;
            $display("[TB] FAIL midreset_after: count=%0d first=%0d required 1/42", got_q.size(), got_q[0]);
        end
    endtask

    task automatic test_sat_counter();
        logic [7:0] exp_cnt;
        configure(8'd1, 5'd0);
        dout_ready = 1'b1;
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        for (int i = 0; i < 300; i++) send(18'sd131071);
        drain();
`ifdef DECIM_SAT_CNT_EN
        exp_cnt = 8'(mdl_cnt);
`else
        exp_cnt = 8'h00;
`endif
        n_tests++;
        if (status[15:8] !== exp_cnt) begin
            n_fail++;
            $display("[TB] FAIL satcnt_saturated: got %h required %h", status[15:8], exp_cnt);
        end
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        n_tests++;
        if (status[15:8] !== 8'h00 || status[3] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL satcnt_clear: cnt=%h sticky=%b required 00/0", status[15:8], status[3]);
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] exp_cnt;
        for (int r = 0; r < 3; r++) begin
            configure(8'($urandom_range(0, 5)), 5'($urandom_range(0, 20)));
            for (int c = 0; c < 150; c++) begin
                din = 18'($urandom);
                din_valid = ($urandom_range(0, 3) != 0);
                dout_ready = ($urandom_range(0, 2) != 0);
                sat_clr = ($urandom_range(0, 40) == 0);
                tick();
            end
            sat_clr = 1'b0;
            drain();
            n_tests++;
            if (got_q.size() != exp_q.size()) begin
                n_fail++;
                $display("[TB] FAIL rand_count[%0d]: got %0d required %0d", r, got_q.size(), exp_q.size());
            end
            for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
                n_tests++;
                if (got_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("[TB] FAIL rand_data[%0d][%0d]: got %0d required %0d", r, k, got_q[k], exp_q[k]);
                end
            end
`ifdef DECIM_SAT_CNT_EN
            exp_cnt = 8'(mdl_cnt);
`else
            exp_cnt = 8'h00;
`endif
            n_tests++;
            if (status[3] !== mdl_sticky || status[15:8] !== exp_cnt) begin
                n_fail++;
                $display("[TB] FAIL rand_sat[%0d]: sticky=%b cnt=%h required %b/%h", r, status[3], status[15:8], mdl_sticky, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_decimation();
        test_requant();
        test_backpressure();
        test_decim_latch();
        test_reset_midstream();
        test_sat_counter();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
